// File: rtl/sevseg_pkg.sv
// Shared encodings for the seven-segment scan decoder: display modes and
// active-low segment patterns (bit0=a .. bit6=g, 0 = lit).
package sevseg_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_NUM   = 3'b111;
    localparam mode_t MODE_STR   = 3'b101;
    localparam mode_t MODE_BLANK = 3'b000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_STR_C = 7'b1000110;
    localparam logic [6:0] SEG_STR_O = 7'b1000000;
    localparam logic [6:0] SEG_STR_N = 7'b0101011;
    localparam logic [6:0] SEG_STR_F = 7'b0001110;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg_to_nibble.sv
// Combinational reverse lookup of one active-low segment pattern into a hex
// nibble; hit_o is low for patterns outside the hex table.
module seg_to_nibble
    import sevseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b1;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_HEX_0: nibble_o = 4'h0;
            SEG_HEX_1: nibble_o = 4'h1;
            SEG_HEX_2: nibble_o = 4'h2;
            SEG_HEX_3: nibble_o = 4'h3;
            SEG_HEX_4: nibble_o = 4'h4;
            SEG_HEX_5: nibble_o = 4'h5;
            SEG_HEX_6: nibble_o = 4'h6;
            SEG_HEX_7: nibble_o = 4'h7;
            SEG_HEX_8: nibble_o = 4'h8;
            SEG_HEX_9: nibble_o = 4'h9;
            SEG_HEX_A: nibble_o = 4'hA;
            SEG_HEX_B: nibble_o = 4'hB;
            SEG_HEX_C: nibble_o = 4'hC;
            SEG_HEX_D: nibble_o = 4'hD;
            SEG_HEX_E: nibble_o = 4'hE;
            SEG_HEX_F: nibble_o = 4'hF;
            default:   hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Rebuilds a 4-digit hex value and display mode from a multiplexed active-low
// seven-segment bus, publishing only after STABLE_FRAMES identical frames.
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [2:0]  mode,
    output logic        value_valid,
    output logic        frame_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       SF       = 4'(STABLE_FRAMES);

    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    logic [3:0][6:0]  slot_q, slot_d;
    logic [3:0]       seen_q, seen_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    mode_t            cand_mode_q, cand_mode_d;
    logic [15:0]      cand_val_q, cand_val_d;
    logic [3:0]       match_q, match_d;
    mode_t            mode_q, mode_d;
    logic [15:0]      value_q, value_d;
    logic             vv_q, vv_d;
    logic             ferr_q, ferr_d;

    logic [3:0]       strobe;
    logic             one_low, idle, illegal;
    logic [3:0]       hit;
    logic [3:0][3:0]  nib;
    logic             cls_ok;
    mode_t            cls_mode;
    logic [15:0]      cls_val;
    logic             same;

    for (genvar g = 0; g < 4; g++) begin : g_dec
        seg_to_nibble u_dec (
            .seg_i    (slot_q[g]),
            .hit_o    (hit[g]),
            .nibble_o (nib[g])
        );
    end

    assign strobe  = ~an_q;
    assign one_low = (strobe != '0) && ((strobe & (strobe - 4'd1)) == '0);
    assign idle    = (an_q == '1);
    assign illegal = !idle && !one_low;

    // String match is tested before hex so the "O" of CONF never reads as 0.
    always_comb begin
        cls_ok   = 1'b1;
        cls_mode = MODE_NUM;
        cls_val  = nib;
        if (slot_q == {4{SEG_BLANK}}) begin
            cls_mode = MODE_BLANK;
            cls_val  = '0;
        end else if (slot_q == {SEG_STR_C, SEG_STR_O, SEG_STR_N, SEG_STR_F}) begin
            cls_mode = MODE_STR;
            cls_val  = '0;
        end else if (!(&hit)) begin
            cls_ok = 1'b0;
        end
    end

    assign same = ({cls_mode, cls_val} == {cand_mode_q, cand_val_q});

    always_comb begin
        slot_d      = slot_q;
        seen_d      = seen_q;
        done_d      = 1'b0;
        tmo_d       = tmo_q;
        cand_mode_d = cand_mode_q;
        cand_val_d  = cand_val_q;
        match_d     = match_q;
        mode_d      = mode_q;
        value_d     = value_q;
        vv_d        = 1'b0;
        ferr_d      = 1'b0;

        if (illegal) begin
            seen_d = '0;
            tmo_d  = '0;
            ferr_d = 1'b1;
        end else if (one_low) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strobe[i]) slot_d[i] = seg_q;
            end
            tmo_d = '0;
            if ((seen_q | strobe) == '1) begin
                seen_d = '0;
                done_d = 1'b1;
            end else begin
                seen_d = seen_q | strobe;
            end
        end else if (seen_q != '0) begin
            if (tmo_q == TMO_LAST) begin
                seen_d = '0;
                tmo_d  = '0;
                ferr_d = 1'b1;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
        end

        // A completed frame is judged one cycle after its last capture; an
        // illegal strobe arriving in that cycle wins and the frame is dropped.
        if (done_q && !illegal) begin
            if (!cls_ok) begin
                ferr_d = 1'b1;
            end else begin
                if (same) begin
                    match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
                end else begin
                    cand_mode_d = cls_mode;
                    cand_val_d  = cls_val;
                    match_d     = 4'd1;
                end
                if ((match_d == SF) && !(same && match_q == SF) &&
                    ({cls_mode, cls_val} != {mode_q, value_q})) begin
                    mode_d  = cls_mode;
                    value_d = cls_val;
                    vv_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '1;
            an_q        <= '1;
            slot_q      <= '0;
            seen_q      <= '0;
            done_q      <= 1'b0;
            tmo_q       <= '0;
            cand_mode_q <= MODE_BLANK;
            cand_val_q  <= '0;
            match_q     <= '0;
            mode_q      <= MODE_BLANK;
            value_q     <= '0;
            vv_q        <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            seg_q       <= seg;
            an_q        <= an;
            slot_q      <= slot_d;
            seen_q      <= seen_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            cand_mode_q <= cand_mode_d;
            cand_val_q  <= cand_val_d;
            match_q     <= match_d;
            mode_q      <= mode_d;
            value_q     <= value_d;
            vv_q        <= vv_d;
            ferr_q      <= ferr_d;
        end
    end

    assign value       = value_q;
    assign mode        = mode_q;
    assign value_valid = vv_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Scoreboard bench: a frame-level reference model queues expected pulses with
// their cycle stamps; a monitor pops and compares whenever the DUT pulses.
module tb_sevseg_scan_decoder;

    localparam int unsigned SF  = 2;
    localparam int unsigned TMO = 4096;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [3:0][6:0] CONF  = {7'b1000110, 7'b1000000, 7'b0101011, 7'b0001110};
    localparam logic [3:0][6:0] BLANK = {4{7'b1111111}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '1;
    logic [3:0]  an = '1;
    logic [15:0] value;
    logic [2:0]  mode;
    logic        value_valid;
    logic        frame_err;

    sevseg_scan_decoder #(
        .STABLE_FRAMES  (SF),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (13)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .mode        (mode),
        .value_valid (value_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        int unsigned cyc;
        logic [15:0] v;
        logic [2:0]  m;
    } ev_t;

    ev_t q[$];
    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned last_s = 0;

    // Reference model state: candidate, match count and published result.
    logic [2:0]  cand_m = 3'b000;
    logic [15:0] cand_v = '0;
    int unsigned cnt = 0;
    logic [2:0]  pub_m = 3'b000;
    logic [15:0] pub_v = '0;
    logic [3:0][6:0] prev_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int find(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (HEX[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [3:0][6:0] hex_frame(input logic [15:0] v);
        logic [3:0][6:0] f;
        for (int d = 0; d < 4; d++) f[d] = HEX[v[d*4 +: 4]];
        return f;
    endfunction

    function automatic void classify(input logic [3:0][6:0] p, output bit ok,
                                     output logic [2:0] m, output logic [15:0] v);
        ok = 1'b1;
        m  = 3'b111;
        v  = '0;
        if (p == BLANK) m = 3'b000;
        else if (p == CONF) m = 3'b101;
        else begin
            for (int d = 0; d < 4; d++) begin
                int idx;
                idx = find(p[d]);
                if (idx < 0) ok = 1'b0;
                else v[d*4 +: 4] = 4'(idx);
            end
        end
    endfunction

    task automatic push_err(input int unsigned c);
        ev_t e;
        e.err = 1'b1; e.cyc = c; e.v = '0; e.m = '0;
        q.push_back(e);
    endtask

    task automatic model_frame(input logic [3:0][6:0] p);
        bit ok;
        bit same;
        int unsigned old;
        logic [2:0] m;
        logic [15:0] v;
        ev_t e;
        classify(p, ok, m, v);
        if (!ok) begin
            push_err(last_s + 2);
            return;
        end
        same = ({m, v} == {cand_m, cand_v});
        old  = cnt;
        if (same) cnt = (cnt < 15) ? cnt + 1 : 15;
        else begin
            cand_m = m; cand_v = v; cnt = 1;
        end
        if (cnt == SF && (!same || old != SF) && {cand_m, cand_v} != {pub_m, pub_v}) begin
            pub_m = m; pub_v = v;
            e.err = 1'b0; e.cyc = last_s + 2; e.v = v; e.m = m;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            an  = 4'hF;
            seg = 7'($urandom);
        end
    endtask

    task automatic strobe(input int unsigned d, input logic [6:0] p);
        @(negedge clk);
        an     = ~(4'b0001 << d);
        seg    = p;
        last_s = cyc + 1;
    endtask

    // Digits go out in random order; sometimes the first digit is first
    // strobed with junk and then overwritten.
    task automatic scan(input logic [3:0][6:0] p);
        int unsigned ord[4];
        for (int i = 0; i < 4; i++) ord[i] = i;
        for (int i = 3; i > 0; i--) begin
            int unsigned j, t;
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        if ($urandom_range(0, 3) == 0) begin
            strobe(ord[0], 7'($urandom));
            idle($urandom_range(0, 1));
        end
        for (int k = 0; k < 4; k++) begin
            strobe(ord[k], p[ord[k]]);
            if (k < 3) idle($urandom_range(0, 2));
        end
        model_frame(p);
        prev_frame = p;
        idle($urandom_range(0, 2));
    endtask

    task automatic check_hold(input string tag);
        idle(4);
        check({tag, "_value"}, value, pub_v);
        check({tag, "_mode"}, mode, pub_m);
    endtask

    function automatic logic [6:0] bad_pat();
        logic [6:0] p;
        do p = 7'($urandom);
        while (find(p) >= 0 || p == 7'b1111111 || p == 7'b0101011);
        return p;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_pulse_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (value_valid || frame_err) begin
                check("pulse_exclusive", {31'b0, value_valid & frame_err}, 0);
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, value_valid, frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_is_err", {31'b0, frame_err}, {31'b0, e.err});
                    if (!e.err) begin
                        check("pub_value", value, e.v);
                        check("pub_mode", mode, e.m);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] p;
        int unsigned r;

        repeat (3) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_mode", mode, 0);
        check("rst_valid", value_valid, 0);
        check("rst_err", frame_err, 0);
        rst_n = 1'b1;
        idle(2);

        scan(hex_frame(16'h1234));
        scan(hex_frame(16'h1234));
        check_hold("num");

        repeat (3) scan(CONF);
        check_hold("conf");

        scan(hex_frame(16'h1234));
        scan(hex_frame(16'h1235));
        scan(hex_frame(16'h1234));
        scan(hex_frame(16'h1234));
        check_hold("flip");

        p = hex_frame(16'hBEEF);
        p[1] = 7'b0101010;
        scan(p);
        check_hold("bad_hold");
        scan(hex_frame(16'hBEEF));
        scan(hex_frame(16'hBEEF));
        check_hold("after_bad");

        // Illegal double strobe mid-frame, then an abandoned 3-digit frame.
        idle(2);
        strobe(0, HEX[1]);
        strobe(2, HEX[3]);
        @(negedge clk);
        an  = 4'b0011;
        seg = 7'($urandom);
        push_err(cyc + 2);
        idle(1);
        strobe(3, HEX[9]);
        strobe(1, HEX[8]);
        strobe(0, HEX[7]);
        push_err(last_s + 1 + TMO);
        idle(TMO + 4);
        check_hold("timeout");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) p = BLANK;
            else if (r == 1) p = CONF;
            else if (r == 2) begin
                p = hex_frame(16'($urandom));
                p[$urandom_range(0, 3)] = bad_pat();
            end else if (r < 7) p = prev_frame;
            else p = hex_frame(16'($urandom));
            scan(p);
        end
        check_hold("random");

        scan(BLANK);
        scan(BLANK);
        check_hold("blank");

        p = hex_frame(pub_v ^ 16'h0F0F);
        scan(p);
        scan(p);
        idle(4);
        strobe(2, HEX[5]);
        strobe(0, HEX[6]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_value", value, 0);
        check("midrst_mode", mode, 0);
        check("midrst_valid", value_valid, 0);
        check("midrst_err", frame_err, 0);
        cand_m = '0; cand_v = '0; cnt = 0; pub_m = '0; pub_v = '0;
        @(negedge clk);
        an = '1;
        rst_n = 1'b1;
        idle(2);
        scan(hex_frame(16'h1234));
        check_hold("post_rst_one");
        scan(hex_frame(16'h1234));
        check_hold("post_rst_two");

        idle(8);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_decoder.md
Name: sevseg_scan_decoder

Overview:
- Receive-side counterpart of the team's 4-digit seven-segment encoder.
- Watches a time-multiplexed display bus: an active-low segment pattern plus active-low one-hot digit enables.
- Rebuilds the 16-bit hex value and the display mode from that bus.
- Used for self-check and readback of the vote display, and as a bench monitor. Publishes only after several identical complete frames.

Parameters:
- STABLE_FRAMES, 2: number of consecutive identical classified frames required before publishing (1..15).
- TIMEOUT_CYCLES, 4096: idle cycles after the last capture before a partial frame is discarded.
- CNT_W, 13: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  active-low segment pattern, bit0=a .. bit6=g; a 0 means the segment is lit.
- an  in  4  active-low digit enable; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=thousands.
- value  out  16  decoded nibbles {thousands, hundreds, tens, ones}.
- mode  out  3  3'b111 numeric, 3'b101 string "CONF", 3'b000 blank.
- value_valid  out  1  one-cycle pulse when value/mode is updated.
- frame_err  out  1  one-cycle pulse on any discarded frame.

Behaviour:
- Reset state: single clock domain, reset asynchronous and active-low (rst_n). While rst_n=0: value=0, mode=000, value_valid=0, frame_err=0; seen mask, slots, candidate, match count and timeout counter all cleared. Reset mid-frame discards everything.
- Input stage: seg and an are registered once (cycle S).
- Capture: registered an with exactly one bit low writes registered seg into that digit's slot and sets its seen bit at S+1. A re-strobed digit overwrites its slot with the latest pattern. an=4'b1111 is idle: no capture, timeout counter increments.
- Illegal strobe: more than one an bit low. The frame is aborted, seen is cleared, frame_err pulses at S+1.
- Frame complete: seen==4'b1111 after a capture. Classification is combinational on the slots; results register at S+2.
  - All slots 7'b1111111 gives mode 000, value 0.
  - Slots thousands..ones == 1000110, 1000000, 0101011, 0001110 give mode 101, value 0. The string check has priority over hex, so the "O" in that pattern is not treated as digit 0.
  - Every slot in the 16-entry hex table gives mode 111, value = the nibbles. Table (0..F): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - Anything else: frame discarded, frame_err pulses, candidate and match count are unchanged.
  - seen clears after every completed frame.
- Stability:
  - Classified {mode, value} equal to the candidate: match count increments, saturating at 15.
  - Otherwise: candidate is replaced and count = 1.
  - When count first reaches STABLE_FRAMES and the candidate differs from the published outputs, value/mode update and value_valid pulses (same cycle, S+2).
  - Equal results are never re-pulsed.
  - The first frame after reset counts toward STABLE_FRAMES. A blank result still publishes if the outputs were not already blank.
- Timeout: the counter clears on each capture and counts while seen != 0. When it reaches TIMEOUT_CYCLES, seen is cleared and frame_err pulses. The candidate is kept.
- Simultaneous events: reset dominates; an illegal strobe dominates frame completion. value_valid and frame_err are never high in the same cycle.

Decomposition:
- Package sevseg_pkg holds:
  - mode encodings MODE_NUM, MODE_STR, MODE_BLANK;
  - SEG_BLANK;
  - the four CONF string constants;
  - the 16 hex segment constants.
- Sub-module seg_to_nibble: combinational 7-bit pattern to {hit, nibble[3:0]}; one instance per slot.

Test Plan:
- Scan 0x1234 digit by digit, 2 full frames: value=16'h1234, mode=111, a single value_valid at S+2 of the 2nd frame's last digit, frame_err never high.
- Scan CONF patterns for 2 frames: mode=101, value=0, one pulse. A 3rd identical frame produces no pulse.
- Frames 0x1234, 0x1235, 0x1234, 0x1234: exactly one publish (0x1234 after frames 3–4); 0x1235 is never published.
- Tens slot = 7'b0101010: frame_err pulse, outputs hold, and the next two good frames publish normally.
- an=4'b0011 mid-frame: frame_err at S+1, partial discarded. A subsequent 3-digit scan followed by silence gives frame_err exactly TIMEOUT_CYCLES after the last capture.
- Assert rst_n low mid-frame after a publish: all outputs 0 immediately, and a fresh 2-frame scan is required to publish again.
